bl_duty_calc: RTL and testbench

BL_DUTY_CALC -- requirements
Module: bl_duty_calc

---
 rtl/bl_duty_calc_pkg.sv | 15 +
 rtl/bl_udiv_seq.sv | 60 ++++++
 rtl/bl_duty_calc.sv | 139 +++++++++++++
 tb/tb_bl_duty_calc.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bl_duty_calc_pkg.sv
// Shared definitions for the backlight duty calculator: FSM encoding and
// default widths/limits used by the top level and the divider.
package bl_duty_calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DUTY_MIN_DEF = 16;
    localparam int SUM_W_DEF    = 32;
    localparam int CNT_W_DEF    = 24;

endpackage

// File: rtl/bl_udiv_seq.sv
// Restoring unsigned divider, one quotient bit per clock over SUM_W clocks.
// The dividend is captured at start; the divisor must stay stable while busy.
module bl_udiv_seq
    import bl_duty_calc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    localparam int CW = $clog2(SUM_W + 1);

    logic [CW-1:0]    r_cnt;
    logic [SUM_W-1:0] r_q;
    logic [CNT_W-1:0] r_rem;
    logic             r_busy;

    logic [CNT_W:0]   w_shift;
    logic             w_ge;
    logic [CNT_W-1:0] w_rem_nxt;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign w_shift   = {r_rem, r_q[SUM_W-1]};
    assign w_ge      = (w_shift >= {1'b0, divisor});
    assign w_rem_nxt = w_ge ? CNT_W'(w_shift - {1'b0, divisor}) : w_shift[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_q    <= dividend;
            r_rem  <= '0;
            r_cnt  <= CW'(SUM_W);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_q   <= {r_q[SUM_W-2:0], w_ge};
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_busy && (r_cnt == CW'(1));
    assign quotient = r_q;

endmodule

// File: rtl/bl_duty_calc.sv
// Per-frame luminance statistics and backlight duty code: accumulates sum,
// count and peak, snapshots them on the output-update edge and divides.
module bl_duty_calc
    import bl_duty_calc_pkg::*;
#(
    parameter int DUTY_MIN = DUTY_MIN_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       iODCK,
    input  logic       iRST_N,
    input  logic       iDE,
    input  logic [7:0] iY,
    input  logic       iOU_en,
    input  logic       iALG_rst,
    output logic [7:0] oDuty,
    output logic       oDuty_valid,
    output logic [7:0] oMax,
    output logic [7:0] oAvg
);

    localparam logic [7:0] DUTY_MIN_C = 8'(DUTY_MIN);

    function automatic logic [7:0] f_avg_clip(input logic [SUM_W-1:0] q,
                                              input logic [CNT_W-1:0] cnt);
        if (cnt == '0)            return 8'd0;
        else if (|q[SUM_W-1:8])   return 8'd255;
        else                      return q[7:0];
    endfunction

    // Rounded midpoint of peak and mean, floored at the minimum duty code.
    function automatic logic [7:0] f_duty(input logic [7:0] mx, input logic [7:0] av);
        logic [8:0] raw;
        raw = ({1'b0, mx} + {1'b0, av} + 9'd1) >> 1;
        if (raw < {1'b0, DUTY_MIN_C}) return DUTY_MIN_C;
        else                          return raw[7:0];
    endfunction

    state_t r_state, w_state_nxt;

    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_max;
    logic [CNT_W-1:0] r_cnt_snap;
    logic [7:0]       r_max_snap;
    logic             r_ou_prev;
    logic [7:0]       r_duty, r_max_o, r_avg_o;
    logic             r_valid;

    logic             w_ou_edge, w_start;
    logic             w_div_busy, w_div_done;
    logic [SUM_W-1:0] w_quot;
    logic [SUM_W:0]   w_sum_add;
    logic [7:0]       w_avg;

    assign w_ou_edge = iOU_en && !r_ou_prev;
    assign w_start   = w_ou_edge && (r_state == ST_IDLE) && !w_div_busy;
    assign w_sum_add = {1'b0, r_sum} + {{(SUM_W-7){1'b0}}, iY};
    assign w_avg     = f_avg_clip(w_quot, r_cnt_snap);

    always_ff @(posedge iODCK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_max <= '0;
        end else if (!iALG_rst) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_max <= '0;
        end else if (iDE) begin
            r_sum <= w_sum_add[SUM_W] ? '1 : w_sum_add[SUM_W-1:0];
            r_cnt <= (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
            r_max <= (iY > r_max) ? iY : r_max;
        end
    end

    // The sum snapshot is the divider's captured dividend.
    always_ff @(posedge iODCK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cnt_snap <= '0;
            r_max_snap <= '0;
            r_ou_prev  <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_ou_prev <= iOU_en;
            r_state   <= w_state_nxt;
            if (w_start) begin
                r_cnt_snap <= r_cnt;
                r_max_snap <= r_max;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start)    w_state_nxt = ST_DIV;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_DONE;
            ST_DONE:                 w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    bl_udiv_seq #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk      (iODCK),
        .rst_n    (iRST_N),
        .start    (w_start),
        .dividend (r_sum),
        .divisor  (r_cnt_snap),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    always_ff @(posedge iODCK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_duty  <= DUTY_MIN_C;
            r_max_o <= '0;
            r_avg_o <= '0;
            r_valid <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_duty  <= f_duty(r_max_snap, w_avg);
            r_max_o <= r_max_snap;
            r_avg_o <= w_avg;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign oDuty       = r_duty;
    assign oDuty_valid = r_valid;
    assign oMax        = r_max_o;
    assign oAvg        = r_avg_o;

endmodule

// File: tb/tb_bl_duty_calc.sv
// Directed bench for bl_duty_calc: table of frames plus hand-written
// overlap, clear-during-divide, abort and reset-edge sequences.
module tb_bl_duty_calc;

    logic       iODCK = 1'b0;
    logic       iRST_N;
    logic       iDE;
    logic [7:0] iY;
    logic       iOU_en;
    logic       iALG_rst;
    logic [7:0] oDuty;
    logic       oDuty_valid;
    logic [7:0] oMax;
    logic [7:0] oAvg;

    int n_chk  = 0;
    int n_fail = 0;

    bl_duty_calc dut (
        .iODCK       (iODCK),
        .iRST_N      (iRST_N),
        .iDE         (iDE),
        .iY          (iY),
        .iOU_en      (iOU_en),
        .iALG_rst    (iALG_rst),
        .oDuty       (oDuty),
        .oDuty_valid (oDuty_valid),
        .oMax        (oMax),
        .oAvg        (oAvg)
    );

    always #5 iODCK = ~iODCK;

    typedef struct {
        string      name;
        int         na;
        logic [7:0] ya;
        int         nb;
        logic [7:0] yb;
        logic [7:0] exp_max;
        logic [7:0] exp_avg;
        logic [7:0] exp_duty;
    } vec_t;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clear_stats();
        iALG_rst = 1'b0;
        repeat (3) @(negedge iODCK);
        iALG_rst = 1'b1;
    endtask

    task automatic send(input int n, input logic [7:0] y);
        if (n > 0) begin
            iDE = 1'b1;
            iY  = y;
            repeat (n) @(negedge iODCK);
            iDE = 1'b0;
            iY  = 8'd0;
        end
    endtask

    // Starts an iOU_en pulse sampled at posedges k=0..2 (k=0 is E), with
    // optional second pulse, statistics clear and reset at given k.
    task automatic run_frame(input int ou2_k, input int clr_k, input int rst_k,
                             output int n_valid, output int valid_k,
                             output logic [7:0] d, output logic [7:0] m,
                             output logic [7:0] a);
        n_valid = 0;
        valid_k = -1;
        d = 8'd0; m = 8'd0; a = 8'd0;
        iOU_en = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge iODCK);
            @(negedge iODCK);
            if (oDuty_valid) begin
                n_valid++;
                valid_k = k;
                d = oDuty; m = oMax; a = oAvg;
            end
            iOU_en   = (k + 1 <= 2) || (ou2_k >= 0 && k + 1 >= ou2_k && k + 1 <= ou2_k + 2);
            iALG_rst = !(clr_k >= 0 && k + 1 >= clr_k && k + 1 <= clr_k + 2);
            iRST_N   = !(rst_k >= 0 && k + 1 >= rst_k && k + 1 <= rst_k + 2);
        end
    endtask

    task automatic chk_frame(input string nm, input int n_valid, input int valid_k,
                             input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                             input logic [7:0] em, input logic [7:0] ea, input logic [7:0] ed);
        chk({nm, " pulses"}, n_valid, 1);
        chk({nm, " latency"}, valid_k, 33);
        chk({nm, " max"}, m, em);
        chk({nm, " avg"}, a, ea);
        chk({nm, " duty"}, d, ed);
    endtask

    vec_t vecs[6];
    int         nv, vk;
    logic [7:0] d, m, a;

    initial begin
        vecs[0] = '{"basic", 2, 8'd100, 2, 8'd200, 8'd200, 8'd150, 8'd175};
        vecs[1] = '{"zero",  0, 8'd0,   0, 8'd0,   8'd0,   8'd0,   8'd16};
        vecs[2] = '{"dark",  10, 8'd10, 0, 8'd0,   8'd10,  8'd10,  8'd16};
        vecs[3] = '{"round", 1, 8'd100, 1, 8'd101, 8'd101, 8'd100, 8'd101};
        vecs[4] = '{"full",  4, 8'd255, 0, 8'd0,   8'd255, 8'd255, 8'd255};
        vecs[5] = '{"mid",   3, 8'd20,  1, 8'd60,  8'd60,  8'd30,  8'd45};

        iRST_N = 1'b0; iDE = 1'b0; iY = 8'd0; iOU_en = 1'b0; iALG_rst = 1'b1;
        repeat (3) @(negedge iODCK);
        chk("reset duty", oDuty, 16);
        chk("reset max", oMax, 0);
        chk("reset avg", oAvg, 0);
        chk("reset valid", oDuty_valid, 0);

        // iOU_en already high at reset release is an edge on the first clock.
        iOU_en = 1'b1;
        iRST_N = 1'b1;
        run_frame(-1, -1, -1, nv, vk, d, m, a);
        chk_frame("rstedge", nv, vk, d, m, a, 8'd0, 8'd0, 8'd16);

        for (int i = 0; i < 6; i++) begin
            clear_stats();
            send(vecs[i].na, vecs[i].ya);
            send(vecs[i].nb, vecs[i].yb);
            run_frame(-1, -1, -1, nv, vk, d, m, a);
            chk_frame(vecs[i].name, nv, vk, d, m, a,
                      vecs[i].exp_max, vecs[i].exp_avg, vecs[i].exp_duty);
        end

        repeat (5) @(negedge iODCK);
        chk("hold duty", oDuty, 45);
        chk("hold max", oMax, 60);
        chk("hold avg", oAvg, 30);
        chk("hold valid", oDuty_valid, 0);

        clear_stats();
        send(2, 8'd50);
        send(2, 8'd250);
        run_frame(10, -1, -1, nv, vk, d, m, a);
        chk_frame("overlap", nv, vk, d, m, a, 8'd250, 8'd150, 8'd200);

        clear_stats();
        send(1, 8'd30);
        send(1, 8'd90);
        run_frame(-1, 5, -1, nv, vk, d, m, a);
        chk_frame("clrdiv", nv, vk, d, m, a, 8'd90, 8'd60, 8'd75);
        send(2, 8'd40);
        run_frame(-1, -1, -1, nv, vk, d, m, a);
        chk_frame("afterclr", nv, vk, d, m, a, 8'd40, 8'd40, 8'd40);

        clear_stats();
        send(3, 8'd120);
        run_frame(-1, -1, 12, nv, vk, d, m, a);
        chk("abort pulses", nv, 0);
        chk("abort duty", oDuty, 16);
        chk("abort max", oMax, 0);
        chk("abort avg", oAvg, 0);

        clear_stats();
        send(1, 8'd60);
        send(1, 8'd180);
        run_frame(-1, -1, -1, nv, vk, d, m, a);
        chk_frame("resume", nv, vk, d, m, a, 8'd180, 8'd120, 8'd150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
